// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI constants and AR-channel state encoding for the instruction-side read bridge.
package inst_axi_rd_bridge_pkg;

    localparam logic [2:0] AXI_ARSIZE_4B  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_1BEAT  = 8'd0;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_t;

    // Simultaneous accept and return leave the in-flight count unchanged.
    function automatic logic [1:0] next_count(input logic [1:0] cnt,
                                              input logic       inc,
                                              input logic       dec);
        logic [1:0] result;
        result = cnt;
        case ({inc, dec})
            2'b10:   result = cnt + 2'd1;
            2'b01:   result = cnt - 2'd1;
            default: result = cnt;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like request/response to single-beat AXI4 reads, with up to
// MAX_OUTSTANDING in-order reads in flight.
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    ar_state_t  ar_state;
    logic [1:0] cnt;

    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN_1BEAT;
    assign arsize  = AXI_ARSIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // Full is judged on the registered count only; a same-cycle return does not free a slot.
    assign inst_sram_addr_ok = inst_sram_en && (ar_state == AR_IDLE) && (cnt < MAX_CNT);

    assign rready            = (cnt != 2'd0);
    assign inst_sram_data_ok = rvalid && rready;
    assign inst_sram_rdata   = rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
            araddr   <= 32'd0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (inst_sram_addr_ok) begin
                        araddr   <= inst_sram_addr;
                        arvalid  <= 1'b1;
                        ar_state <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        ar_state <= AR_IDLE;
                    end
                end
                default: begin
                    arvalid  <= 1'b0;
                    ar_state <= AR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 2'd0;
        end else begin
            cnt <= next_count(cnt, inst_sram_addr_ok, inst_sram_data_ok);
        end
    end

    // Fetch never drives these; fold them into a sink so the ports stay documented.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wen, inst_sram_size, inst_sram_wdata, rid, rresp, rlast};

    a_cnt_bounded: assert property (@(posedge clk) disable iff (reset) cnt <= MAX_CNT);
    a_ar_stable: assert property (@(posedge clk) disable iff (reset)
        arvalid && !arready |=> arvalid && $stable(araddr));

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized + directed scoreboard bench for inst_axi_rd_bridge against a
// transaction-level model of the bridge.
module tb_inst_axi_rd_bridge;

    localparam int MAX = 2;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    inst_axi_rd_bridge #(
        .MAX_OUTSTANDING(MAX),
        .AXI_ID(4'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inst_sram_en(inst_sram_en),
        .inst_sram_wen(inst_sram_wen),
        .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid),
        .araddr(araddr),
        .arlen(arlen),
        .arsize(arsize),
        .arburst(arburst),
        .arlock(arlock),
        .arcache(arcache),
        .arprot(arprot),
        .arvalid(arvalid),
        .arready(arready),
        .rid(rid),
        .rdata(rdata),
        .rresp(rresp),
        .rlast(rlast),
        .rvalid(rvalid),
        .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks_total  = 0;
    int checks_passed = 0;

    // Transaction model: in-flight count, pending AR, issued-but-unreturned
    // addresses, and the words the fetch stage should see, in order.
    int          m_cnt  = 0;
    bit          m_busy = 0;
    logic [31:0] m_araddr = 32'd0;
    logic [31:0] r_q[$];
    logic [31:0] exp_data[$];
    logic [31:0] mem[logic [31:0]];

    task automatic check_word(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (!mem.exists(addr)) mem[addr] = $urandom;
        return mem[addr];
    endfunction

    task automatic clear_model();
        m_cnt  = 0;
        m_busy = 0;
        m_araddr = 32'd0;
        r_q.delete();
        exp_data.delete();
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic ardy,
                                 input logic want_r, input logic spurious);
        @(negedge clk);
        inst_sram_en   = en;
        inst_sram_addr = addr;
        arready        = ardy;
        if (want_r && r_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(r_q[0]);
        end else if (spurious && m_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = $urandom;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        rid   = 4'($urandom_range(0, 15));
        rresp = 2'($urandom_range(0, 3));
        rlast = 1'b1;
    endtask

    task automatic checkOutput();
        bit          exp_aok;
        bit          exp_dok;
        logic [31:0] w;
        exp_aok = inst_sram_en && !m_busy && (m_cnt < MAX);
        exp_dok = rvalid && (m_cnt != 0);
        check_bit("addr_ok", inst_sram_addr_ok, exp_aok);
        check_bit("arvalid", arvalid, m_busy);
        check_bit("rready", rready, m_cnt != 0);
        check_bit("data_ok", inst_sram_data_ok, exp_dok);
        if (m_busy) check_word("araddr", araddr, m_araddr);
        if (inst_sram_data_ok) begin
            if (exp_data.size() == 0) begin
                check_bit("scoreboard_nonempty", 1'b0, 1'b1);
            end else begin
                w = exp_data.pop_front();
                check_word("rdata", inst_sram_rdata, w);
            end
        end
        if (exp_dok && r_q.size() > 0) void'(r_q.pop_front());
        if (m_busy && arready) begin
            r_q.push_back(m_araddr);
            m_busy = 0;
        end else if (exp_aok) begin
            m_busy   = 1;
            m_araddr = inst_sram_addr;
            exp_data.push_back(mem_word(inst_sram_addr));
        end
        m_cnt = m_cnt + int'(exp_aok) - int'(exp_dok);
    endtask

    // Monitor: evaluates every cycle between the driving negedge and the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) checkOutput();
        end
    end

    initial begin
        reset = 1'b1;
        inst_sram_en = 1'b0;
        inst_sram_wen = 4'd0;
        inst_sram_size = 2'd2;
        inst_sram_addr = 32'd0;
        inst_sram_wdata = 32'd0;
        arready = 1'b0;
        rid = 4'd0;
        rdata = 32'd0;
        rresp = 2'd0;
        rlast = 1'b0;
        rvalid = 1'b0;

        #2;
        check_bit("rst_arvalid", arvalid, 1'b0);
        check_word("rst_araddr", araddr, 32'd0);
        check_bit("rst_rready", rready, 1'b0);
        check_bit("rst_addr_ok", inst_sram_addr_ok, 1'b0);
        check_bit("rst_data_ok", inst_sram_data_ok, 1'b0);
        check_word("arsize", {29'd0, arsize}, 32'd2);
        check_word("arburst", {30'd0, arburst}, 32'd1);
        check_word("arlen", {24'd0, arlen}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        #1 reset = 1'b0;

        // Single fetch with minimum latency
        mem[32'h1c000000] = 32'h02800000;
        applyStimulus(1, 32'h1c000000, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // AR backpressure for five cycles with fetch still requesting
        applyStimulus(1, 32'h1c000010, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h1c000014, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Outstanding limit: third request held off until a return frees a slot
        applyStimulus(1, 32'h1c000000, 1, 0, 0);
        applyStimulus(1, 32'h1c000000, 1, 0, 0);
        applyStimulus(1, 32'h1c000004, 1, 0, 0);
        applyStimulus(1, 32'h1c000008, 1, 0, 0);
        applyStimulus(1, 32'h1c000008, 1, 0, 0);
        applyStimulus(1, 32'h1c000008, 1, 1, 0);
        applyStimulus(1, 32'h1c000008, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0);

        // In-order return on consecutive cycles
        mem[32'h1c000100] = 32'hAAAA0000;
        mem[32'h1c000104] = 32'hBBBB0000;
        applyStimulus(1, 32'h1c000100, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 32'h1c000104, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);

        // Accept and return in the same cycle at one in flight, then spurious rvalid
        applyStimulus(1, 32'h1c000200, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 32'h1c000204, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Asynchronous reset while AR is stalled with two in flight
        applyStimulus(1, 32'h1c000300, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 32'h1c000304, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #3 reset = 1'b1;
        clear_model();
        #1;
        check_bit("async_rst_arvalid", arvalid, 1'b0);
        check_bit("async_rst_rready", rready, 1'b0);
        check_bit("async_rst_addr_ok", inst_sram_addr_ok, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        mem[32'h1c000400] = 32'h12345678;
        applyStimulus(1, 32'h1c000400, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          32'h1c000000 + (32'($urandom_range(0, 63)) << 2),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) == 0);
        end

        // Drain with a bounded budget
        for (int i = 0; i < 50 && (exp_data.size() != 0 || m_busy); i++) begin
            applyStimulus(0, 0, 1, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        check_word("drain_pending", 32'(exp_data.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
